muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage.
- Accepts one operation per start pulse and holds `busy` so the core stalls until the operation completes.
- Iterates one bit per cycle: shift-add for multiply, restoring division for divide.
- Signs are normalised before iteration and corrected after it.

Parameters:
XLEN, 32, operand/result width; also the iteration count.

Ports:
clk     input   1     clock, rising edge
rst_n   input   1     asynchronous active-low reset
start   input   1     request; accepted only in IDLE
funct3  input   3     M-extension funct3 (000 MUL … 111 REMU), sampled on accept
op_a    input   XLEN  rs1 value (multiplicand/dividend), sampled on accept
op_b    input   XLEN  rs2 value (multiplier/divisor), sampled on accept
busy    output  1     high from the cycle after accept through the FIX cycle
done    output  1     one-cycle pulse; result valid
result  output  XLEN  final value, held until the next accept

Behaviour:
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared. No pending operation survives reset.
- States:
  - IDLE: start=1 → latch funct3/operands, record signs, load magnitudes, counter=XLEN-1 → CALC.
  - CALC: one iteration per cycle. counter==0 → FIX; otherwise decrement.
  - FIX: apply sign correction and special cases; write result → DONE.
  - DONE: done=1, busy=0 → IDLE.
- Latency: accept at edge E0; done is high in the cycle after edge E0+XLEN+1, i.e. XLEN+2 cycles after accept (34 for XLEN=32). start sampled in DONE is ignored. Back-to-back throughput is one op per XLEN+3 cycles.
- start while busy or in DONE is ignored with no side effects. Input changes after accept have no effect.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - Signed operands are converted to magnitudes.
- Multiply: 2·XLEN-bit product. Negated in FIX if the operand signs differ. MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide: quotient negated if the signs differ; remainder takes the sign of the dividend.
- Divide by zero (op_b=0): quotient = all ones; remainder = op_a unchanged. Applies to signed and unsigned.
- Signed overflow (op_a=0x8000_0000, op_b=-1, DIV/REM): quotient = 0x8000_0000, remainder = 0.
- Special cases still take the full latency unless the optional feature is enabled.
- result changes only on the FIX→DONE transition.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, if op_b==0, or op_a==0, or the DIV/REM overflow case applies, the FSM goes directly to FIX. done then asserts 2 cycles after accept; result values are identical to the full path.
- Undefined: every operation takes the full XLEN+2 cycles. Deterministic latency is preserved for timing analysis.

Decomposition:
- Package muldiv_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE);
  - funct3 localparams F3_MUL … F3_REMU;
  - helper functions is_div(funct3) and a_signed/b_signed(funct3).
- No sub-module. Iteration datapath and FSM stay in one module of roughly 200 lines.

Test Plan:
1. Reset, then MUL op_a=7, op_b=0xFFFF_FFFD → done exactly 34 cycles after accept, result=0xFFFF_FFEB, busy high in cycles 1–33.
2. MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE. MULH same operands → 0x0000_0000. MULHSU 0xFFFF_FFFF×2 → 0xFFFF_FFFF.
3. DIV −7/2 → 0xFFFF_FFFD. REM −7/2 → 0xFFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
4. DIVU 5/0 → 0xFFFF_FFFF. REMU 5/0 → 5. DIV 0x8000_0000/−1 → 0x8000_0000. REM same → 0. With MULDIV_EARLY_OUT_EN, done 2 cycles after accept for each.
5. Pulse start with new operands at cycles 5 and 33 during a busy op → ignored. The original result is returned and the next accept happens only from IDLE.
6. Assert rst_n=0 asynchronously at cycle 10 of a DIV → busy, done and result go to 0 immediately. After release, a fresh MUL 3×4 returns 12 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer:
// FSM state encoding, funct3 opcodes and operand-signedness decoding.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic is_div(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic a_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Bit-serial RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Build option: define MULDIV_EARLY_OUT_EN to skip iteration for trivial operands.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_hi, r_lo, r_b, r_a_raw, r_result;
  logic            r_neg_a, r_neg_b, r_b_zero, r_ovf;
  logic [CW-1:0]   r_count;

  // Operand decode at accept
  logic            w_neg_a, w_neg_b, w_b_zero, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  assign w_neg_a  = a_signed(funct3) & op_a[XLEN-1];
  assign w_neg_b  = b_signed(funct3) & op_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? -op_a : op_a;
  assign w_mag_b  = w_neg_b ? -op_b : op_b;
  assign w_b_zero = (op_b == '0);
  assign w_ovf    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == MIN_NEG) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = w_b_zero || (op_a == '0) || w_ovf;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
          w_state_nxt = w_early ? S_FIX : S_CALC;
`else
          w_state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_count == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // One iteration: multiply accumulates into r_hi and shifts the multiplier out of r_lo;
  // divide shifts the dividend out of r_lo into the partial remainder in r_hi.
  logic [XLEN:0]   w_mul_sum, w_div_rem;
  logic            w_div_ge;
  logic [XLEN-1:0] w_div_sub, w_hi_nxt, w_lo_nxt;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_rem = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge  = (w_div_rem >= {1'b0, r_b});
  assign w_div_sub = w_div_rem[XLEN-1:0] - r_b;

  always_comb begin
    w_hi_nxt = w_mul_sum[XLEN:1];
    w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    if (is_div(r_f3)) begin
      w_hi_nxt = w_div_ge ? w_div_sub : w_div_rem[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_div_ge};
    end
  end

  // Sign correction and special cases applied in FIX
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_fix;
  logic              w_is_rem;

  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo_s  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem_s  = r_neg_a ? -r_hi : r_hi;
  assign w_is_rem = (r_f3 == F3_REM) || (r_f3 == F3_REMU);

  always_comb begin
    w_fix = '0;
    if (is_div(r_f3)) begin
      if (r_b_zero)   w_fix = w_is_rem ? r_a_raw : '1;
      else if (r_ovf) w_fix = w_is_rem ? '0 : MIN_NEG;
      else            w_fix = w_is_rem ? w_rem_s : w_quo_s;
    end else if (!r_b_zero) begin
      w_fix = (r_f3 == F3_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b_zero <= 1'b0;
      r_ovf    <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f3     <= funct3;
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_b      <= w_mag_b;
            r_a_raw  <= op_a;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_b_zero <= w_b_zero;
            r_ovf    <= w_ovf;
            r_count  <= CW'(XLEN-1);
          end
        end
        S_CALC: begin
          r_hi <= w_hi_nxt;
          r_lo <= w_lo_nxt;
          if (r_count != '0) r_count <= r_count - 1'b1;
        end
        S_FIX:   r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed RV32M results, latency,
// busy/done framing, ignored start pulses and asynchronous reset mid-operation.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, optionally pulse start while busy
  // (sampled at cycles 5 and 33) and in DONE, then check result, latency and framing.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input bit special, input bit inject);
    int k;
    bit busy_ok;
    int exp_lat;
    exp_lat = (special && EARLY) ? 2 : XLEN + 2;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = ~f; op_a = ~a; op_b = b ^ 32'h5;
    k = 0;
    busy_ok = 1'b1;
    while (k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      start = 1'b0;
      if (inject && (k == 4 || k == 32)) begin
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'h0000_1234; op_b = 32'h2;
      end
    end
    check({tag, " result"}, result, exp);
    check({tag, " latency"}, 32'(k + 1), 32'(exp_lat));
    check({tag, " busy during op"}, {31'b0, busy_ok}, 32'd1);
    check({tag, " busy at done"}, {31'b0, busy}, 32'd0);
    start = inject;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " idle busy"}, {31'b0, busy}, 32'd0);
    check({tag, " done one cycle"}, {31'b0, done}, 32'd0);
    check({tag, " result held"}, result, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    #12;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("MUL 7*-3",          F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
    do_op("MULHU -1*-1",       F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("MULH -1*-1",        F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    do_op("MULHSU -1*2",       F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("DIV -7/2",          F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op("REM -7/2",          F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("DIVU 100/7",        F3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0, 1'b0);
    do_op("REMU 100/7",        F3_REMU,   32'd100,        32'd7,         32'd2,         1'b0, 1'b0);
    do_op("DIVU 5/0",          F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("REMU 5/0",          F3_REMU,   32'd5,          32'd0,         32'd5,         1'b1, 1'b0);
    do_op("DIV -5/0",          F3_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("REM -5/0",          F3_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1, 1'b0);
    do_op("DIV min/-1",        F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
    do_op("REM min/-1",        F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    do_op("MUL 0*5",           F3_MUL,    32'd0,          32'd5,         32'd0,         1'b1, 1'b0);
    do_op("MUL ignored start", F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst busy", {31'b0, busy}, 32'd0);
    check("async rst done", {31'b0, done}, 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("MUL 3*4 after rst", F3_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
